mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 18-bit 4-to-1 select datapath between four independent requesters.
- Picks one valid requester per cycle and drives the 2-bit select code.
- Captures the selected word into a registered output stage with a valid/ready handshake.
- Sits between the four producer channels and the single downstream consumer of the muxed word.

Parameters:
- DATA_WIDTH, 18: width of each requester word and of out_data.
- LAST_INIT, 3: reset value of the last-grant pointer, so requester 0 has highest priority after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_data_a  input  DATA_WIDTH  requester 0 word.
- in_data_b  input  DATA_WIDTH  requester 1 word.
- in_data_c  input  DATA_WIDTH  requester 2 word.
- in_data_d  input  DATA_WIDTH  requester 3 word.
- in_ready  output  4  one-hot accept strobe; requester i's word is taken when in_valid[i] & in_ready[i].
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  DATA_WIDTH  registered selected word.
- out_sel  output  2  registered select code of the word in out_data (0=a, 1=b, 2=c, 3=d).
- busy  output  1  out_valid | (|in_valid).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Output stage has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = ~out_valid | out_ready. Loading a new word while the current one is consumed gives one word per cycle.
- Grant (combinational): search in_valid circularly, starting at (last+1) mod 4 and ending at last. The first set bit is the grant g.
  - No bit set means no grant.
- in_ready[g]=1 only when load=1 and a grant exists. Every other in_ready bit is 0.
  - in_ready never depends on in_data.
  - in_ready may depend on in_valid and out_ready.
- On accept:
  - out_data <= selected word, where select code g maps 0→a, 1→b, 2→c, 3→d.
  - out_sel <= g.
  - out_valid <= 1.
  - last <= g.
- If load=1 and there is no grant, out_valid <= 0. out_data and out_sel hold their stale values.
- If out_valid=1 and out_ready=0, out_data, out_sel and out_valid hold. All in_ready bits are 0, so there is backpressure to every requester.
- Latency: a word accepted in cycle N appears on out_data with out_valid=1 in cycle N+1.
- Fairness: with all four requesters continuously valid and out_ready=1, the grant order is 0,1,2,3,0,... A requester waits at most 3 other grants.
- A requester that drops in_valid without being granted loses nothing, and last does not change.
- Simultaneous requests: exactly one is granted per cycle. The ungranted ones stay pending and must hold their data.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, last=LAST_INIT.
  - in_ready=0 throughout the reset cycle.
  - busy reflects in_valid while reset is asserted.
- Reset mid-transfer: a word held in the output register is dropped, and out_valid=0 the cycle after reset is sampled.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds input in_lock (4 bits).
  - When the word just accepted from requester g had in_lock[g]=1, g keeps the grant on later cycles while in_valid[g]=1, regardless of the round-robin order.
  - The lock releases on the first accept with in_lock[g]=0, or when in_valid[g] drops.
  - last updates normally on each accept.
- Undefined:
  - The in_lock port does not exist.
  - Pure round-robin as described above.

Test Plan:
- Reset, then in_valid=4'b1111 with a=18'h01234, b=18'h05678, c=18'h09abc, d=18'h0def0, and out_ready=1 held → out_sel sequence 0,1,2,3,0 on consecutive cycles starting cycle 1 after the first accept. out_data tracks each word. out_valid stays 1.
- in_valid=4'b0100 only, c=18'h3FFFF → in_ready=4'b0100. Next cycle out_data=18'h3FFFF, out_sel=2.
- Output FULL with out_ready=0 for 5 cycles, in_valid=4'b1010 → in_ready=0 throughout. out_data stable. On release, b is granted first if last=0.
- last=1, in_valid=4'b0011 → grant 0 (wrap-around), then 1.
- Assert reset while out_valid=1 and in_valid=4'b1111 → next cycle out_valid=0 and out_sel=0. The first grant after reset is requester 0.
- MUX_ARB_LOCK_EN defined: in_valid=4'b1001, in_lock[3]=1 for 3 accepts, then 0 → d is granted 4 consecutive times, then a.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing an 18-bit 4:1 select path, with a registered valid/ready output stage.
// Optional grant locking is enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arbiter #(
    parameter int         DATA_WIDTH = 18,
    parameter logic [1:0] LAST_INIT  = 2'd3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            in_valid,
    input  logic [DATA_WIDTH-1:0] in_data_a,
    input  logic [DATA_WIDTH-1:0] in_data_b,
    input  logic [DATA_WIDTH-1:0] in_data_c,
    input  logic [DATA_WIDTH-1:0] in_data_d,
`ifdef MUX_ARB_LOCK_EN
    input  logic [3:0]            in_lock,
`endif
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_sel,
    output logic                  busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t            state_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [1:0]            sel_reg;
    logic [1:0]            last_reg;

    logic                  load;
    logic                  grant_valid;
    logic [1:0]            grant_idx;
    logic                  accept;
    logic [DATA_WIDTH-1:0] words [4];

    assign words[0] = in_data_a;
    assign words[1] = in_data_b;
    assign words[2] = in_data_c;
    assign words[3] = in_data_d;

    assign out_valid = (state_reg == FULL);
    assign out_data  = data_reg;
    assign out_sel   = sel_reg;
    assign busy      = out_valid | (|in_valid);

    // Reset suppresses every accept so nothing is taken during the reset cycle.
    assign load   = (~out_valid | out_ready) & ~reset;
    assign accept = load & grant_valid;

`ifdef MUX_ARB_LOCK_EN
    logic lock_reg;
`endif

    // Walk from the farthest position back toward last+1 so the nearest valid requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (in_valid[last_reg + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = last_reg + 2'(k);
            end
        end
`ifdef MUX_ARB_LOCK_EN
        if (lock_reg && in_valid[last_reg]) begin
            grant_valid = 1'b1;
            grant_idx   = last_reg;
        end
`endif
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ready
            assign in_ready[gi] = accept && (grant_idx == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            sel_reg   <= 2'd0;
            last_reg  <= LAST_INIT;
        end else if (load) begin
            if (grant_valid) begin
                state_reg <= FULL;
                data_reg  <= words[grant_idx];
                sel_reg   <= grant_idx;
                last_reg  <= grant_idx;
            end else begin
                state_reg <= EMPTY;
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    // The lock belongs to the most recent grantee, which is always last_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_reg <= 1'b0;
        end else if (accept) begin
            lock_reg <= in_lock[grant_idx];
        end else if (lock_reg && !in_valid[last_reg]) begin
            lock_reg <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios followed by random traffic,
// all compared against a behavioural round-robin model.
module tb_mux_rr_arbiter;

    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    in_valid;
    logic [DW-1:0] in_data_a, in_data_b, in_data_c, in_data_d;
    logic [3:0]    in_lock;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          busy;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_WIDTH(DW), .LAST_INIT(2'd3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data_a (in_data_a),
        .in_data_b (in_data_b),
        .in_data_c (in_data_c),
        .in_data_d (in_data_d),
`ifdef MUX_ARB_LOCK_EN
        .in_lock   (in_lock),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_sel;
    int            m_last;
    logic          m_lock;
    logic [3:0]    obs_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        case (i)
            0:       return in_data_a;
            1:       return in_data_b;
            2:       return in_data_c;
            default: return in_data_d;
        endcase
    endfunction

    // First valid requester in circular order (last+1) .. last, or -1 for none.
    function automatic int model_grant();
`ifdef MUX_ARB_LOCK_EN
        if (m_lock && in_valid[m_last]) return m_last;
`endif
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic step();
        int         g;
        logic       ld;
        logic [3:0] exp_ready;
        #2;
        g  = model_grant();
        ld = (!m_valid || out_ready) && !reset;
        exp_ready = 4'b0000;
        if (ld && g >= 0) exp_ready[g] = 1'b1;
        obs_ready = in_ready;
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_ready});
        chk("busy", {31'd0, busy}, {31'd0, m_valid | (|in_valid)});
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = 3; m_lock = 1'b0;
        end else begin
            if (ld && g >= 0) begin
                m_valid = 1'b1;
                m_data  = word_of(g);
                m_sel   = g;
                m_last  = g;
                m_lock  = in_lock[g];
            end else begin
                if (m_lock && !in_valid[m_last]) m_lock = 1'b0;
                if (ld) m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_data", {14'd0, out_data}, {14'd0, m_data});
        chk("out_sel", {30'd0, out_sel}, 32'(m_sel));
        $display("t=%0t rst=%0b v=%b rdy_in=%b ordy=%0b -> ov=%0b sel=%0d data=%h",
                 $time, reset, in_valid, obs_ready, out_ready, out_valid, out_sel, out_data);
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = 3; m_lock = 1'b0;
        reset = 1'b1; in_valid = 4'b0000; out_ready = 1'b1; in_lock = 4'b0000;
        in_data_a = 18'h01234; in_data_b = 18'h05678;
        in_data_c = 18'h09abc; in_data_d = 18'h0def0;

        // Reset state
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sel", {30'd0, out_sel}, 32'd0);
        chk("rst_out_data", {14'd0, out_data}, 32'd0);
        reset = 1'b0;

        // All four continuously valid: strict 0,1,2,3,0 rotation
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_order", {30'd0, out_sel}, 32'(k % 4));
            chk("rr_valid", {31'd0, out_valid}, 32'd1);
        end

        // Single requester c with an all-ones word
        in_valid = 4'b0100; in_data_c = 18'h3FFFF;
        step();
        chk("c_ready", {28'd0, obs_ready}, 32'h4);
        chk("c_data", {14'd0, out_data}, 32'h3FFFF);
        chk("c_sel", {30'd0, out_sel}, 32'd2);

        // Fill with a (last=0), then hold backpressure for 5 cycles
        in_valid = 4'b0001;
        step();
        in_valid = 4'b1010; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_ready", {28'd0, obs_ready}, 32'd0);
            chk("bp_data", {14'd0, out_data}, 32'h01234);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_sel", {30'd0, out_sel}, 32'd1);

        // last=1: wrap-around to 0, then 1
        in_valid = 4'b0011;
        step();
        chk("wrap_first", {30'd0, out_sel}, 32'd0);
        step();
        chk("wrap_second", {30'd0, out_sel}, 32'd1);

        // Reset while full with all requesters valid
        in_valid = 4'b1111; reset = 1'b1;
        step();
        chk("midrst_ready", {28'd0, obs_ready}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sel", {30'd0, out_sel}, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_grant", {30'd0, out_sel}, 32'd0);

`ifdef MUX_ARB_LOCK_EN
        // d locks the grant for three accepts, the fourth releases, then a
        in_valid = 4'b1001; in_lock = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) in_lock = 4'b0000;
            step();
            chk("lock_d", {30'd0, out_sel}, 32'd3);
        end
        step();
        chk("lock_release_a", {30'd0, out_sel}, 32'd0);
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 49) == 0);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_lock   = 4'($urandom);
            in_data_a = 18'($urandom); in_data_b = 18'($urandom);
            in_data_c = 18'($urandom); in_data_d = 18'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
